logicnet_input_quantizer: RTL and testbench

- Front-end stage that feeds the first LogicNet layer's neuron LUTs.
- Accepts raw signed feature samples one per beat on a valid/ready stream and quantizes each to a 2-bit code using three thresholds.
- Packs the codes into the layer-0 input vector and presents it, held stable, on a valid/ready output until consumed.

---
 rtl/logicnet_q_pkg.sv | 25 ++
 rtl/logicnet_q_threshold.sv | 16 +
 rtl/logicnet_input_quantizer.sv | 169 ++++++++++++++++
 tb/tb_logicnet_input_quantizer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logicnet_q_pkg.sv
// Shared types and the quantization rule for the LogicNet input quantizer.
// Thresholds are compared as 32-bit signed ints, so IN_WIDTH may not exceed 32.
package logicnet_q_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [1:0] Q_LOW    = 2'b00;
    localparam logic [1:0] Q_MID_LO = 2'b01;
    localparam logic [1:0] Q_MID_HI = 2'b10;
    localparam logic [1:0] Q_HIGH   = 2'b11;

    // A sample equal to a threshold falls into the higher bin.
    function automatic logic [1:0] quantize(input int sample, input int t0,
                                            input int t1, input int t2);
        if (sample < t0)      return Q_LOW;
        else if (sample < t1) return Q_MID_LO;
        else if (sample < t2) return Q_MID_HI;
        else                  return Q_HIGH;
    endfunction

endpackage

// File: rtl/logicnet_q_threshold.sv
// Purely combinational three-threshold comparator: signed sample -> 2-bit code.
module logicnet_q_threshold
    import logicnet_q_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int T0       = -64,
    parameter int T1       = 0,
    parameter int T2       = 64
) (
    input  logic signed [IN_WIDTH-1:0] sample_i,
    output logic        [1:0]          code_o
);

    assign code_o = quantize(int'(sample_i), T0, T1, T2);

endmodule

// File: rtl/logicnet_input_quantizer.sv
// Quantizes a stream of signed feature samples into packed 2-bit codes for LogicNet layer 0.
// Optional macro LOGICNET_QPIPE_EN adds a register stage ahead of the comparator.
module logicnet_input_quantizer
    import logicnet_q_pkg::*;
#(
    parameter int NUM_FEATURES = 3,
    parameter int IN_WIDTH     = 8,
    parameter int T0           = -64,
    parameter int T1           = 0,
    parameter int T2           = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [IN_WIDTH-1:0]    s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [2*NUM_FEATURES-1:0]     m_data,
    output logic                          err_early,
    output logic                          err_late
);

    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int VW    = 2 * NUM_FEATURES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    if (!(T0 < T1 && T1 < T2)) begin : g_bad_thresholds
        $error("logicnet_input_quantizer: thresholds must satisfy T0 < T1 < T2");
    end
    if (NUM_FEATURES < 1) begin : g_bad_features
        $error("logicnet_input_quantizer: NUM_FEATURES must be at least 1");
    end

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VW-1:0]         pack_q, pack_d;
    logic                  err_early_q, err_early_d;
    logic                  err_late_q, err_late_d;

    logic                  s_fire;
    logic [1:0]            code;

    // Commit event: the beat whose code is written into the pack register this cycle.
    logic                  c_vld;
    logic signed [IN_WIDTH-1:0] c_data;
    logic [IDX_W-1:0]      c_idx;
    logic                  c_last;

    assign s_fire = s_valid && s_ready;

`ifdef LOGICNET_QPIPE_EN
    logic                  p_vld_q;
    logic signed [IN_WIDTH-1:0] p_data_q;
    logic [IDX_W-1:0]      p_idx_q;
    logic                  p_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_vld_q  <= 1'b0;
            p_data_q <= '0;
            p_idx_q  <= '0;
            p_last_q <= 1'b0;
        end else begin
            p_vld_q <= s_fire;
            if (s_fire) begin
                p_data_q <= s_data;
                p_idx_q  <= idx_q;
                p_last_q <= s_last;
            end
        end
    end

    assign c_vld  = p_vld_q;
    assign c_data = p_data_q;
    assign c_idx  = p_idx_q;
    assign c_last = p_last_q;
    // The frame closes on the next edge, so nothing may slip into the stage behind it.
    assign s_ready = !rst && (state_q != HOLD) && !(p_vld_q && p_last_q);
`else
    assign c_vld   = s_fire;
    assign c_data  = s_data;
    assign c_idx   = idx_q;
    assign c_last  = s_last;
    assign s_ready = !rst && (state_q != HOLD);
`endif

    logicnet_q_threshold #(
        .IN_WIDTH (IN_WIDTH),
        .T0       (T0),
        .T1       (T1),
        .T2       (T2)
    ) u_thr (
        .sample_i (c_data),
        .code_o   (code)
    );

    // Slot index follows accepted beats; it wraps at the frame end or on s_last.
    always_comb begin
        idx_d = idx_q;
        if (s_fire) begin
            if (s_last || idx_q == LAST_IDX) idx_d = '0;
            else                             idx_d = idx_q + 1'b1;
        end
        if (state_q == HOLD && m_ready) idx_d = '0;
    end

    always_comb begin
        state_d     = state_q;
        pack_d      = pack_q;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (c_vld) begin
                    for (int i = 0; i < NUM_FEATURES; i++) begin
                        if (i == int'(c_idx))
                            pack_d[2*i +: 2] = code;
                        else if (c_last && i > int'(c_idx))
                            pack_d[2*i +: 2] = Q_LOW;
                    end
                    if (c_last) begin
                        state_d     = HOLD;
                        err_early_d = (c_idx != LAST_IDX);
                    end else if (c_idx == LAST_IDX) begin
                        state_d    = DRAIN;
                        err_late_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (c_vld && c_last) state_d = HOLD;
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = COLLECT;
                    pack_d  = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                pack_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            pack_q      <= '0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pack_q      <= pack_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
        end
    end

    assign m_valid   = (state_q == HOLD);
    assign m_data    = pack_q;
    assign err_early = err_early_q;
    assign err_late  = err_late_q;

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Scoreboard bench for logicnet_input_quantizer: random frames vs. a frame-level reference model.
module tb_logicnet_input_quantizer;

    localparam int NF = 3;
    localparam int W  = 8;
    localparam int T0 = -64;
    localparam int T1 = 0;
    localparam int T2 = 64;
`ifdef LOGICNET_QPIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [W-1:0]  s_data;
    logic                 s_last;
    logic                 m_valid;
    logic                 m_ready;
    logic [2*NF-1:0]      m_data;
    logic                 err_early;
    logic                 err_late;

    logicnet_input_quantizer #(
        .NUM_FEATURES (NF),
        .IN_WIDTH     (W),
        .T0           (T0),
        .T1           (T1),
        .T2           (T2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err_early (err_early),
        .err_late  (err_late)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*NF-1:0] data;
        int              early;
        int              late;
    } exp_t;

    exp_t exp_q[$];
    int   last_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   hold_mr  = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [1:0] ref_code(input int x);
        if (x < T0) return 2'd0;
        if (x < T1) return 2'd1;
        if (x < T2) return 2'd2;
        return 2'd3;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected frame: first NF samples quantized, missing slots zero, one error flag by frame length.
    task automatic send_frame(input int samp[$], input bit gaps);
        exp_t e;
        int   n;
        bit   fire;
        int   waited;
        n = samp.size();
        e.data = '0;
        for (int i = 0; i < n && i < NF; i++) e.data[2*i +: 2] = ref_code(samp[i]);
        e.early = (n < NF) ? 1 : 0;
        e.late  = (n > NF) ? 1 : 0;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    s_valid = 1'b0;
                    s_data  = W'($urandom);
                    s_last  = 1'($urandom);
                    step();
                end
            end
            s_valid = 1'b1;
            s_data  = W'(samp[i]);
            s_last  = (i == n - 1);
            waited  = 0;
            forever begin
                fire = s_ready;
                if (fire && i == n - 1) last_q.push_back(cyc);
                step();
                if (fire) break;
                waited++;
                if (waited > 200) begin
                    check("s_ready_timeout", 0, 1);
                    break;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // m_ready: mostly high, with occasional long stalls.
    initial begin
        int stall = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (hold_mr) m_ready = 1'b0;
            else if (stall > 0) begin
                m_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 7) == 0) begin
                stall   = 5;
                m_ready = 1'b0;
            end else m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares presented vectors, latency, stability and error pulses.
    initial begin
        bit              prev_v  = 1'b0;
        bit              hs_prev = 1'b0;
        bit              hs;
        int              ce = 0;
        int              cl = 0;
        logic [2*NF-1:0] held = '0;
        exp_t            e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0; hs_prev = 1'b0; ce = 0; cl = 0;
                continue;
            end
            if (err_early) ce++;
            if (err_late)  cl++;
            if (hs_prev) check("s_ready_after_handshake", s_ready, 1);
            if (m_valid) check("s_ready_in_hold", s_ready, 0);
            if (m_valid && !prev_v) begin
                if (last_q.size() == 0) check("unexpected_m_valid", 1, 0);
                else check("latency", cyc - last_q.pop_front(), LAT);
                held = m_data;
            end else if (m_valid) begin
                check("m_data_stable", m_data, held);
            end
            hs = m_valid && m_ready;
            if (hs) begin
                if (exp_q.size() == 0) check("unexpected_vector", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.data);
                    check("err_early_pulses", ce, e.early);
                    check("err_late_pulses", cl, e.late);
                end
                ce = 0;
                cl = 0;
            end
            prev_v  = m_valid && !hs;
            hs_prev = hs;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        check("watchdog_expired", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        int fr[$];
        int waited;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        step();
        step();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_err_early", err_early, 0);
        check("rst_err_late", err_late, 0);
        rst = 1'b0;
        step();
        check("s_ready_after_rst", s_ready, 1);

        fr = '{-100, 0, 64};           send_frame(fr, 1'b0);
        fr = '{-64, -1, 63};           send_frame(fr, 1'b0);
        fr = '{100};                   send_frame(fr, 1'b0);
        fr = '{10, 10, 10, 127};       send_frame(fr, 1'b0);
        fr = '{-128, 127, -65};        send_frame(fr, 1'b1);

        for (int f = 0; f < 80; f++) begin
            int n = $urandom_range(1, 5);
            fr.delete();
            for (int i = 0; i < n; i++) begin
                int edges[8] = '{-64, -65, 0, -1, 63, 64, -128, 127};
                if ($urandom_range(0, 9) < 3) fr.push_back(edges[$urandom_range(0, 7)]);
                else fr.push_back($signed(W'($urandom)));
            end
            send_frame(fr, 1'b1);
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            step();
            waited++;
        end
        check("queue_drained", exp_q.size(), 0);

        // Reset while a vector is pending must drop it silently.
        hold_mr = 1'b1;
        step();
        fr = '{5, -5, 70};
        send_frame(fr, 1'b0);
        waited = 0;
        while (!m_valid && waited < 10) begin
            step();
            waited++;
        end
        check("hold_before_rst", m_valid, 1);
        rst = 1'b1;
        step();
        check("rst_in_hold_m_valid", m_valid, 0);
        check("rst_in_hold_m_data", m_data, 0);
        check("rst_in_hold_s_ready", s_ready, 0);
        check("rst_in_hold_err", {err_early, err_late}, 0);
        exp_q.delete();
        last_q.delete();
        rst = 1'b0;
        step();
        check("s_ready_after_rst_hold", s_ready, 1);
        hold_mr = 1'b0;
        fr = '{-100, 0, 64};
        send_frame(fr, 1'b0);
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            step();
            waited++;
        end
        check("final_drain", exp_q.size(), 0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
